// File: rtl/r200_pkg.sv
// Shared r200 core constants and types used across the pipeline blocks.
package r200_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

   // One IF/ID pipeline entry; the buffer stores it as a single packed word.
   typedef struct packed {
      logic [XLEN-1:0] instrn;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pcp4;
   } ifid_entry_t;

   localparam int unsigned ENTRY_W = $bits(ifid_entry_t);

endpackage

// File: rtl/r200_ifid_buf_if.sv
// Fetch-to-decode handshake bundle; the buffer is the slave, its neighbours the master.
interface r200_ifid_buf_if;
   import r200_pkg::*;

   logic [XLEN-1:0] if_instrn;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_pcp4;
   logic            if_valid;
   logic            if_ready;
   logic [XLEN-1:0] id_instrn;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_pcp4;
   logic            id_valid;
   logic            id_ready;
   logic            flush;
   logic [15:0]     stall_cnt;

   modport slave (
      input  if_instrn, if_pc, if_pcp4, if_valid, id_ready, flush,
      output if_ready, id_instrn, id_pc, id_pcp4, id_valid, stall_cnt
   );

   modport master (
      output if_instrn, if_pc, if_pcp4, if_valid, id_ready, flush,
      input  if_ready, id_instrn, id_pc, id_pcp4, id_valid, stall_cnt
   );

endinterface

// File: rtl/r200_fifo2.sv
// Generic 2-entry FIFO with pointer/count control; payload storage is not reset.
module r200_fifo2 #(
   parameter int unsigned W = 96
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] mem_q [2];
   logic         wptr_q, wptr_d;
   logic         rptr_q, rptr_d;
   logic [1:0]   count_q, count_d;

   // Flush wins over any push/pop in the same cycle and re-aligns both pointers.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = 1'b0;
         rptr_d  = 1'b0;
         count_d = 2'd0;
      end else begin
         if (push_i) wptr_d = ~wptr_q;
         if (pop_i)  rptr_d = ~rptr_q;
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= 1'b0;
         rptr_q  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/r200_ifid_buf.sv
// IF/ID skid buffer: two-deep queue between fetch and decode, NOP masking and stall counting.
module r200_ifid_buf
   import r200_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input logic           clk,
   input logic           rst_n,
   r200_ifid_buf_if.slave bus
);

   logic        push;
   logic        pop;
   logic        ifReady;
   logic        idValid;
   logic [1:0]  count;
   ifid_entry_t wrEntry;
   ifid_entry_t rdEntry;
   logic [15:0] stallCnt_q, stallCnt_d;

   // Ready/valid come only from the registered count, so decode never loops back into fetch.
   assign ifReady = (count != 2'd2);
   assign idValid = (count != 2'd0);
   assign push    = bus.if_valid & ifReady & ~bus.flush;
   assign pop     = idValid & bus.id_ready & ~bus.flush;

   assign wrEntry = '{instrn: bus.if_instrn, pc: bus.if_pc, pcp4: bus.if_pcp4};

   r200_fifo2 #(.W(ENTRY_W)) uFifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (bus.flush),
      .wdata_i (wrEntry),
      .rdata_o (rdEntry),
      .count_o (count)
   );

   always_comb begin
      stallCnt_d = stallCnt_q;
      if (bus.if_valid && !ifReady && !bus.flush && (stallCnt_q != 16'hFFFF))
         stallCnt_d = stallCnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stallCnt_q <= 16'd0;
      else        stallCnt_q <= stallCnt_d;
   end

   // Empty head shows a NOP so decode sees a harmless instruction.
   always_comb begin
      bus.id_instrn = NOP_INSTR;
      bus.id_pc     = '0;
      bus.id_pcp4   = '0;
      if (idValid) begin
         bus.id_instrn = rdEntry.instrn;
         bus.id_pc     = rdEntry.pc;
         bus.id_pcp4   = rdEntry.pcp4;
      end
   end

   assign bus.id_valid  = idValid;
   assign bus.if_ready  = ifReady;
   assign bus.stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_r200_ifid_buf.sv
// Directed bench for r200_ifid_buf with a queue-based reference model checked every cycle.
module tb_r200_ifid_buf;
   import r200_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   testsRun = 0;
   int   testsFailed = 0;

   r200_ifid_buf_if bus ();

   r200_ifid_buf dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: an ordered list of at most two entries plus a saturating stall tally.
   ifid_entry_t modelQ[$];
   logic [15:0] modelStall = 16'h0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         modelQ.delete();
         modelStall = 16'h0;
      end else if (bus.flush) begin
         modelQ.delete();
      end else begin
         automatic bit canTake = (modelQ.size() < 2);
         if (bus.if_valid && !canTake && modelStall != 16'hFFFF) modelStall = modelStall + 16'd1;
         if (modelQ.size() > 0 && bus.id_ready) void'(modelQ.pop_front());
         if (bus.if_valid && canTake)
            modelQ.push_back('{instrn: bus.if_instrn, pc: bus.if_pc, pcp4: bus.if_pcp4});
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      automatic bit          expValid = (modelQ.size() != 0);
      automatic logic [31:0] expInstr = expValid ? modelQ[0].instrn : NOP_INSTR_DEFAULT;
      automatic logic [31:0] expPc    = expValid ? modelQ[0].pc : 32'h0;
      automatic logic [31:0] expPcp4  = expValid ? modelQ[0].pcp4 : 32'h0;
      checkOutput("model id_valid", {31'b0, bus.id_valid}, {31'b0, expValid});
      checkOutput("model id_instrn", bus.id_instrn, expInstr);
      checkOutput("model id_pc", bus.id_pc, expPc);
      checkOutput("model id_pcp4", bus.id_pcp4, expPcp4);
      checkOutput("model if_ready", {31'b0, bus.if_ready}, {31'b0, (modelQ.size() != 2)});
      checkOutput("model stall_cnt", {16'b0, bus.stall_cnt}, {16'b0, modelStall});
   end

   // Holds one set of inputs across a single rising edge, returning just after it.
   task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic r, input logic f);
      bus.if_valid  = v;
      bus.if_instrn = instr;
      bus.if_pc     = instr + 32'h1000_0000;
      bus.if_pcp4   = instr + 32'h1000_0004;
      bus.id_ready  = r;
      bus.flush     = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.if_valid  = 1'b0;
      bus.if_instrn = '0;
      bus.if_pc     = '0;
      bus.if_pcp4   = '0;
      bus.id_ready  = 1'b0;
      bus.flush     = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset id_valid", {31'b0, bus.id_valid}, 32'h0);
      checkOutput("reset id_instrn", bus.id_instrn, 32'h0);
      checkOutput("reset if_ready", {31'b0, bus.if_ready}, 32'h1);
      checkOutput("reset stall_cnt", {16'b0, bus.stall_cnt}, 32'h0);
      rst_n = 1'b1;

      for (int i = 1; i <= 6; i++) begin
         automatic logic [31:0] w = 32'h2000_0000 | (i << 16) | i;
         applyStimulus(1'b1, w, 1'b1, 1'b0);
         checkOutput("stream id_instrn", bus.id_instrn, w);
         checkOutput("stream id_pc", bus.id_pc, w + 32'h1000_0000);
         checkOutput("stream if_ready", {31'b0, bus.if_ready}, 32'h1);
      end
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("stream drained", {31'b0, bus.id_valid}, 32'h0);

      applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
      checkOutput("bp ready after A", {31'b0, bus.if_ready}, 32'h1);
      applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
      checkOutput("bp ready after B", {31'b0, bus.if_ready}, 32'h0);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);
         checkOutput("bp stall_cnt", {16'b0, bus.stall_cnt}, i);
      end
      checkOutput("bp head A", bus.id_instrn, 32'hA);
      applyStimulus(1'b1, 32'hC, 1'b1, 1'b0);
      checkOutput("bp head B", bus.id_instrn, 32'hB);
      checkOutput("bp stall final", {16'b0, bus.stall_cnt}, 32'h4);
      applyStimulus(1'b1, 32'hC, 1'b1, 1'b0);
      checkOutput("bp head C", bus.id_instrn, 32'hC);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("bp drained", {31'b0, bus.id_valid}, 32'h0);

      applyStimulus(1'b1, 32'hE, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hF, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hD, 1'b0, 1'b1);
      checkOutput("flush id_valid", {31'b0, bus.id_valid}, 32'h0);
      checkOutput("flush if_ready", {31'b0, bus.if_ready}, 32'h1);
      checkOutput("flush stall_cnt", {16'b0, bus.stall_cnt}, 32'h4);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("flush no D", {31'b0, bus.id_valid}, 32'h0);

      applyStimulus(1'b1, 32'h1, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h2, 1'b1, 1'b0);
      checkOutput("simul id_instrn", bus.id_instrn, 32'h2);
      checkOutput("simul id_valid", {31'b0, bus.id_valid}, 32'h1);
      checkOutput("simul if_ready", {31'b0, bus.if_ready}, 32'h1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

      applyStimulus(1'b1, 32'h44, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h55, 1'b0, 1'b0);
      bus.if_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst id_valid", {31'b0, bus.id_valid}, 32'h0);
      checkOutput("midrst id_instrn", bus.id_instrn, 32'h0);
      checkOutput("midrst if_ready", {31'b0, bus.if_ready}, 32'h1);
      checkOutput("midrst stall_cnt", {16'b0, bus.stall_cnt}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(1'b1, 32'h33, 1'b0, 1'b0);
      checkOutput("postrst head", bus.id_instrn, 32'h33);
      checkOutput("postrst ready", {31'b0, bus.if_ready}, 32'h1);
      applyStimulus(1'b1, 32'h34, 1'b0, 1'b0);
      checkOutput("postrst full", {31'b0, bus.if_ready}, 32'h0);

      repeat (65600) applyStimulus(1'b1, 32'h99, 1'b0, 1'b0);
      checkOutput("sat stall_cnt", {16'b0, bus.stall_cnt}, 32'h0000_FFFF);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/r200_ifid_buf.md
R200_IFID_BUF -- requirements
Module: r200_ifid_buf

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000000, instruction word driven on id_instrn when id_valid=0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 if_instrn  input  32  fetched instruction from fetch stage.
REQ-005 if_pc  input  32  PC of fetched instruction.
REQ-006 if_pcp4  input  32  PC+4 of fetched instruction.
REQ-007 if_valid  input  1  fetch stage presents a valid instruction this cycle.
REQ-008 if_ready  output  1  buffer accepts an entry this cycle; also the PC-hold (stall) signal to fetch.
REQ-009 id_instrn  output  32  head-entry instruction to decode.
REQ-010 id_pc  output  32  head-entry PC.
REQ-011 id_pcp4  output  32  head-entry PC+4.
REQ-012 id_valid  output  1  head entry valid.
REQ-013 id_ready  input  1  decode consumes the head entry this cycle.
REQ-014 flush  input  1  discard all buffered and incoming entries (taken branch/jump redirect).
REQ-015 stall_cnt  output  16  saturating count of fetch-stall cycles.

Function
REQ-016 Storage SHALL be a 2-entry FIFO of {instrn, pc, pcp4}, with 1-bit write pointer, 1-bit read pointer, and 2-bit count (0..2).
REQ-017 if_ready SHALL equal (count != 2) and SHALL be a function of registered state only (no combinational path from id_ready).
REQ-018 push = if_valid & if_ready & ~flush; pop = id_valid & id_ready & ~flush.
REQ-019 id_valid SHALL equal (count != 0); id_instrn/id_pc/id_pcp4 SHALL show the entry at the read pointer.
REQ-020 When id_valid=0, id_instrn SHALL be NOP_INSTR and id_pc/id_pcp4 SHALL be 32'h0.
REQ-021 Latency: an entry pushed at edge N SHALL appear on id_* after edge N (next cycle); no same-cycle bypass.
REQ-022 push without pop: count+1, write pointer toggles. Pop without push: count-1, read pointer toggles.
REQ-023 Simultaneous push and pop (count=1 only): count unchanged, both pointers toggle; the new entry becomes head after the edge.
REQ-024 Push at count=2 SHALL not occur (if_ready=0); if_valid is ignored and fetch data is dropped by this block (fetch holds PC).
REQ-025 Pop at count=0 SHALL not occur (id_valid=0); id_ready is ignored.
REQ-026 flush SHALL have priority: at the edge, count:=0 and both pointers:=0; that cycle's push and pop are discarded; id_valid=0 in the following cycle.
REQ-027 stall_cnt SHALL increment by 1 on each edge where if_valid & ~if_ready & ~flush, saturate at 16'hFFFF, and clear only on reset.
REQ-028 Payload storage registers need no reset; only control state and stall_cnt are reset.

Reset
REQ-029 On rst_n=0, asynchronously: count=0, pointers=0, stall_cnt=0; thus id_valid=0, id_instrn=NOP_INSTR, id_pc=id_pcp4=0, if_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all entries; the first push after rst_n deassertion behaves as a push into an empty buffer.

Structure
REQ-031 NOP_INSTR default value and the entry field widths (32) SHALL live in the shared r200 package with the other core constants.
REQ-032 One sub-module is natural: r200_fifo2, a generic 2-entry FIFO (96-bit payload) instantiated once; stall counter and NOP muxing stay in r200_ifid_buf.

Verification
REQ-033 Reset: rst_n=0 mid-stream with count=2 -> next cycle id_valid=0, id_instrn=0x00000000, if_ready=1, stall_cnt=0.
REQ-034 Streaming: if_valid=1 and id_ready=1 continuously with instrn 0x20010001, 0x20020002, ... -> each appears on id_instrn exactly one cycle after push, in order, if_ready stays 1.
REQ-035 Backpressure: id_ready=0, push 0xA, 0xB, 0xC -> if_ready=0 after the 2nd push, 0xC not accepted, stall_cnt increments by 1 per held cycle; release id_ready -> 0xA, 0xB, then 0xC (re-presented by fetch) in order.
REQ-036 Flush: count=2 with flush=1 and if_valid=1 (0xD) in the same cycle -> next cycle id_valid=0, count=0, 0xD absent.
REQ-037 Simultaneous push and pop at count=1 (head 0x1, push 0x2) -> next cycle id_instrn=0x2, id_valid=1, if_ready=1.
REQ-038 Saturation: force 70000 stall cycles -> stall_cnt holds 16'hFFFF.
